// File: rtl/vga_sdram_port.sv
// vga_sdram_port
// Serves one VGA line-fetch request (BURST_WORDS words, 64 bytes by default)
// by issuing BURST_WORDS/CORE_BL read commands to the SDRAM core. Returned
// words are forwarded to the VGA side one cycle after the core presents them.
// A one-cycle complete pulse follows the final word.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   vga_sdram_req/addr    line request and its byte address (low line bits ignored)
//   vga_sdram_ack         one-cycle pulse when the request is accepted
//   vga_sdram_rdata/rdvalid  returned word stream, in address order
//   vga_sdram_complete    one-cycle pulse after the last word
//   core_req/core_addr    read command to the core, held until core_gnt
//   core_gnt              core accepted the command this cycle
//   core_rdata/rvalid     data returned by the core
//   err_unexpected        sticky: core data arrived with nothing outstanding
//
// state | meaning
// IDLE  | waiting for a line request
// ACK   | acknowledge pulse to the VGA side
// CMD   | issuing core read commands (data may already be returning)
// WAIT  | all commands granted, collecting the remaining words
// DONE  | complete pulse, then back to IDLE
module vga_sdram_port #(
  parameter int BURST_WORDS = 16,
  parameter int CORE_BL     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vga_sdram_req,
  input  logic [25:0] vga_sdram_addr,
  output logic        vga_sdram_ack,
  output logic [31:0] vga_sdram_rdata,
  output logic        vga_sdram_rdvalid,
  output logic        vga_sdram_complete,
  output logic        core_req,
  output logic [25:0] core_addr,
  input  logic        core_gnt,
  input  logic [31:0] core_rdata,
  input  logic        core_rvalid,
  output logic        err_unexpected
);

  localparam int NCMD = BURST_WORDS / CORE_BL;
  localparam int CW   = (NCMD > 1) ? $clog2(NCMD) : 1;
  localparam int BW   = $clog2(BURST_WORDS) + 1;
  localparam logic [CW-1:0] LAST_CMD   = CW'(NCMD - 1);
  localparam logic [BW-1:0] BEATS      = BW'(BURST_WORDS);
  localparam logic [25:0]   CMD_STRIDE = 26'(CORE_BL * 4);
  localparam logic [25:0]   LINE_MASK  = ~26'(BURST_WORDS * 4 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_CMD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [25:0]     base;
  logic [CW-1:0]   cmd_idx;
  logic [BW-1:0]   beat_cnt;
  logic            burst_active;
  logic            beat_take;

  // Data is accepted only while a burst is in flight and words are still owed.
  assign burst_active = (state == S_CMD) || (state == S_WAIT);
  assign beat_take    = core_rvalid && burst_active && (beat_cnt < BEATS);

  // Address tracks cmd_idx directly so it holds steady until the grant.
  assign core_addr = base + 26'(cmd_idx) * CMD_STRIDE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    vga_sdram_ack      = 1'b0;
    core_req           = 1'b0;
    vga_sdram_complete = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (vga_sdram_req) state_nxt = S_ACK;
      end
      S_ACK: begin
        vga_sdram_ack = 1'b1;
        state_nxt     = S_CMD;
      end
      S_CMD: begin
        core_req = 1'b1;
        if (core_gnt && (cmd_idx == LAST_CMD)) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // beat_cnt reaches BEATS on the same edge the last word is registered,
        // so this cycle is the one presenting the final rdvalid.
        if (beat_cnt == BEATS) state_nxt = S_DONE;
      end
      S_DONE: begin
        vga_sdram_complete = 1'b1;
        state_nxt          = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base              <= '0;
      cmd_idx           <= '0;
      beat_cnt          <= '0;
      vga_sdram_rdata   <= '0;
      vga_sdram_rdvalid <= 1'b0;
      err_unexpected    <= 1'b0;
    end else begin
      if ((state == S_IDLE) && vga_sdram_req) begin
        base     <= vga_sdram_addr & LINE_MASK;
        cmd_idx  <= '0;
        beat_cnt <= '0;
      end else begin
        if ((state == S_CMD) && core_gnt) cmd_idx <= cmd_idx + CW'(1);
        if (beat_take) beat_cnt <= beat_cnt + BW'(1);
      end
      vga_sdram_rdvalid <= beat_take;
      if (beat_take) vga_sdram_rdata <= core_rdata;
      if (core_rvalid && !beat_take) err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_sdram_port.sv
// tb_vga_sdram_port
// Self-checking bench for vga_sdram_port. A behavioural core model grants
// commands and returns four words per grant; the expected VGA-side stream is
// derived from line arithmetic (base = addr with low 6 bits cleared, command
// k at base + 16*k, each word visible one cycle after the core drives it).
module tb_vga_sdram_port;

  localparam int NCMD  = 4;
  localparam int BEATS = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vga_sdram_req = 1'b0;
  logic [25:0] vga_sdram_addr = '0;
  logic        vga_sdram_ack;
  logic [31:0] vga_sdram_rdata;
  logic        vga_sdram_rdvalid;
  logic        vga_sdram_complete;
  logic        core_req;
  logic [25:0] core_addr;
  logic        core_gnt = 1'b0;
  logic [31:0] core_rdata = '0;
  logic        core_rvalid = 1'b0;
  logic        err_unexpected;

  vga_sdram_port #(.BURST_WORDS(16), .CORE_BL(4)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .vga_sdram_req      (vga_sdram_req),
    .vga_sdram_addr     (vga_sdram_addr),
    .vga_sdram_ack      (vga_sdram_ack),
    .vga_sdram_rdata    (vga_sdram_rdata),
    .vga_sdram_rdvalid  (vga_sdram_rdvalid),
    .vga_sdram_complete (vga_sdram_complete),
    .core_req           (core_req),
    .core_addr          (core_addr),
    .core_gnt           (core_gnt),
    .core_rdata         (core_rdata),
    .core_rvalid        (core_rvalid),
    .err_unexpected     (err_unexpected)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit err_exp = 1'b0;

  typedef struct {
    logic [25:0] addr;
    logic [25:0] next_addr;   // address presented after ack when req is kept high
    int          stall;       // gnt-low cycles per command; negative = random
    int          lat;         // grant-to-first-data cycles
    bit          gaps;        // random holes in the returned data
    bit          keep;        // keep req high through complete
    int          ack_at;      // cycle (after req is driven) where ack is expected
    logic [25:0] exp_base;    // expected first command address
  } line_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_ack", vga_sdram_ack, 0);
      chk("idle_rdvalid", vga_sdram_rdvalid, 0);
      chk("idle_complete", vga_sdram_complete, 0);
      chk("idle_core_req", core_req, 0);
      chk("idle_err", err_unexpected, err_exp);
    end
  endtask

  task automatic run_line(input line_t l, input int abort_beats);
    int cyc = 0;
    int ncmd = 0;
    int nbeat = 0;
    int comp_at = -1;
    int stall_cnt = 0;
    int cur_stall;
    bit prev_sent = 1'b0;
    bit req_exp;
    logic [31:0] prev_data = '0;
    logic [31:0] d;
    logic [25:0] ea;
    logic [31:0] pq[$];
    int pr[$];
    vga_sdram_req  = 1'b1;
    vga_sdram_addr = l.addr;
    cur_stall = (l.stall < 0) ? int'($urandom_range(0, 4)) : l.stall;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 600) begin
        n_chk++;
        $display("FAIL line_timeout: got %0d beats expected %0d", nbeat, BEATS);
        break;
      end
      req_exp = (cyc > l.ack_at) && (ncmd < NCMD);
      chk("ack", vga_sdram_ack, 32'(cyc == l.ack_at));
      chk("core_req", core_req, 32'(req_exp));
      if (req_exp) begin
        ea = l.exp_base + 26'(ncmd * 16);
        chk("core_addr", 32'(core_addr), 32'(ea));
      end
      chk("rdvalid", vga_sdram_rdvalid, 32'(prev_sent));
      if (prev_sent) begin
        chk("rdata", vga_sdram_rdata, prev_data);
        nbeat++;
        if (nbeat == BEATS) comp_at = cyc + 1;
      end
      chk("complete", vga_sdram_complete, 32'(cyc == comp_at));
      chk("err", err_unexpected, 32'(err_exp));
      if (cyc == comp_at) break;
      if (abort_beats > 0 && nbeat == abort_beats) break;
      if (cyc == l.ack_at) begin
        if (l.keep) vga_sdram_addr = l.next_addr;
        else vga_sdram_req = 1'b0;
      end
      core_gnt = 1'b0;
      if (core_req && ncmd < NCMD) begin
        if (stall_cnt < cur_stall) stall_cnt++;
        else begin
          core_gnt  = 1'b1;
          ncmd++;
          stall_cnt = 0;
          cur_stall = (l.stall < 0) ? int'($urandom_range(0, 4)) : l.stall;
          for (int k = 0; k < 4; k++) begin
            pq.push_back($urandom);
            pr.push_back(cyc + 1 + l.lat);
          end
        end
      end
      prev_sent   = 1'b0;
      core_rvalid = 1'b0;
      if (pq.size() > 0 && pr[0] <= cyc && (!l.gaps || $urandom_range(0, 1) == 1)) begin
        d = pq.pop_front();
        void'(pr.pop_front());
        core_rvalid = 1'b1;
        core_rdata  = d;
        prev_sent   = 1'b1;
        prev_data   = d;
      end
    end
    core_gnt    = 1'b0;
    core_rvalid = 1'b0;
  endtask

  line_t tbl[5];
  line_t rl;

  initial begin
    tbl[0] = '{26'h0123457, 26'h0, 0, 0, 1'b0, 1'b0, 1, 26'h0123440};  // zero-wait
    tbl[1] = '{26'h0ABCDEF, 26'h0, 5, 2, 1'b0, 1'b0, 1, 26'h0ABCDC0};  // grant stalls
    tbl[2] = '{26'h1000000, 26'h0, 3, 0, 1'b1, 1'b0, 1, 26'h1000000};  // interleaved data
    tbl[3] = '{26'h2000041, 26'h200009F, 1, 1, 1'b0, 1'b1, 1, 26'h2000040}; // back-to-back, 1st
    tbl[4] = '{26'h200009F, 26'h0, 0, 0, 1'b0, 1'b0, 2, 26'h2000080};  // back-to-back, 2nd

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", vga_sdram_ack, 0);
    chk("rst_rdvalid", vga_sdram_rdvalid, 0);
    chk("rst_rdata", vga_sdram_rdata, 0);
    chk("rst_complete", vga_sdram_complete, 0);
    chk("rst_core_req", core_req, 0);
    chk("rst_core_addr", 32'(core_addr), 0);
    chk("rst_err", err_unexpected, 0);
    reset_n = 1'b1;
    tick_idle(2);

    for (int i = 0; i < 5; i++) begin
      run_line(tbl[i], 0);
      if (!tbl[i].keep) tick_idle(2);
    end

    for (int i = 0; i < 20; i++) begin
      rl.addr      = 26'($urandom);
      rl.next_addr = '0;
      rl.stall     = -1;
      rl.lat       = int'($urandom_range(0, 3));
      rl.gaps      = 1'b1;
      rl.keep      = 1'b0;
      rl.ack_at    = 1;
      rl.exp_base  = rl.addr & ~26'h3F;
      run_line(rl, 0);
      tick_idle(1);
    end

    // stray core data while idle
    core_rvalid = 1'b1;
    core_rdata  = 32'hDEADBEEF;
    @(posedge clk); #1;
    core_rvalid = 1'b0;
    chk("stray_rdvalid", vga_sdram_rdvalid, 0);
    chk("stray_err", err_unexpected, 1);
    err_exp = 1'b1;
    tick_idle(1);
    rl = '{26'h0555555, 26'h0, 2, 1, 1'b1, 1'b0, 1, 26'h0555540};
    run_line(rl, 0);
    tick_idle(1);

    // reset after 7 beats
    rl = '{26'h1234567, 26'h0, 0, 0, 1'b0, 1'b0, 1, 26'h1234540};
    run_line(rl, 7);
    vga_sdram_req = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ack", vga_sdram_ack, 0);
    chk("mid_rst_rdvalid", vga_sdram_rdvalid, 0);
    chk("mid_rst_rdata", vga_sdram_rdata, 0);
    chk("mid_rst_complete", vga_sdram_complete, 0);
    chk("mid_rst_core_req", core_req, 0);
    chk("mid_rst_core_addr", 32'(core_addr), 0);
    chk("mid_rst_err", err_unexpected, 0);
    err_exp = 1'b0;
    @(posedge clk); #1;
    chk("held_rst_complete", vga_sdram_complete, 0);
    reset_n = 1'b1;
    // leftover word from the abandoned burst
    core_rvalid = 1'b1;
    core_rdata  = 32'h0BADF00D;
    @(posedge clk); #1;
    core_rvalid = 1'b0;
    chk("late_rdvalid", vga_sdram_rdvalid, 0);
    chk("late_complete", vga_sdram_complete, 0);
    chk("late_err", err_unexpected, 1);
    err_exp = 1'b1;
    tick_idle(1);
    rl = '{26'h3FFFFC0, 26'h0, 1, 0, 1'b0, 1'b0, 1, 26'h3FFFFC0};
    run_line(rl, 0);
    tick_idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_sdram_port.md
Name: vga_sdram_port

Overview:
SDRAM-controller-side responder for the VGA line-fetch read protocol (req/addr/ack/rdata/rdvalid/complete). It accepts one 64-byte cache-line request from the VGA pixel front end and splits it into BURST_WORDS/CORE_BL read commands to the SDRAM core. It streams the returned 32-bit words back in address order, then signals completion. It sits inside the SDRAM controller, between the VGA port and the core command/data path.

Parameters:
BURST_WORDS, 16, words per VGA request (64 bytes); must be a multiple of CORE_BL.
CORE_BL, 4, words returned per core read command.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
vga_sdram_req  input  1  line-fetch request from the VGA cache
vga_sdram_addr  input  26  byte address of the line; bits [5:0] are ignored
vga_sdram_ack  output  1  one-cycle pulse: request accepted
vga_sdram_rdata  output  32  returned word
vga_sdram_rdvalid  output  1  vga_sdram_rdata valid this cycle
vga_sdram_complete  output  1  one-cycle pulse: line finished
core_req  output  1  read command valid to the SDRAM core
core_addr  output  26  command byte address, 16-byte aligned
core_gnt  input  1  core accepted the command this cycle
core_rdata  input  32  core read data
core_rvalid  input  1  core_rdata valid
err_unexpected  output  1  sticky: core_rvalid arrived while no beats were outstanding

Behaviour:
- Reset: reset_n low clears asynchronously. All outputs go to 0 (including vga_sdram_rdata and core_addr), state goes to IDLE, counters go to 0, err_unexpected is cleared.
- A reset in the middle of a burst abandons the burst. No complete is issued. Any core data arriving afterwards is treated as unexpected.
- States: IDLE, ACK, CMD, WAIT, DONE.
- IDLE:
  - On a clock edge with vga_sdram_req=1, latch base = {vga_sdram_addr[25:6], 6'b0}, clear cmd_idx and beat_cnt, and go to ACK.
- ACK:
  - vga_sdram_ack=1 for exactly this one cycle (first cycle after req is sampled); go to CMD.
  - vga_sdram_req is ignored from ACK until the return to IDLE. The requester drops req after seeing ack.
  - A req still high on re-entry to IDLE starts a new transaction.
- CMD:
  - core_req=1, core_addr = base + cmd_idx*CORE_BL*4.
  - core_req and core_addr stay stable until core_gnt.
  - On core_gnt, cmd_idx increments. When the last command (cmd_idx = BURST_WORDS/CORE_BL-1) is granted, deassert core_req on the next cycle and go to WAIT.
- Data path (any state):
  - On core_rvalid with beat_cnt < BURST_WORDS and a burst active (CMD or WAIT), register the data.
  - Next cycle: vga_sdram_rdata = core_rdata and vga_sdram_rdvalid = 1. Latency is fixed at 1 cycle, with no buffering or backpressure; the VGA side always accepts.
  - beat_cnt increments; words are delivered in core return order, which is address order.
  - Data may arrive while later commands are still pending, so CMD and data reception overlap.
- WAIT → DONE: on the cycle the BURST_WORDS-th word is registered. That is also the cycle in which it is presented on vga_sdram_rdvalid.
- DONE: vga_sdram_complete=1 for exactly one cycle, the cycle after the final rdvalid; then go to IDLE.
- Unexpected data:
  - core_rvalid in IDLE, ACK or DONE, or beyond BURST_WORDS beats, is dropped, with no rdvalid.
  - It sets err_unexpected, which stays set until reset.
- Widths:
  - core_addr wraps mod 2^26.
  - cmd_idx is $clog2(BURST_WORDS/CORE_BL) bits; beat_cnt is $clog2(BURST_WORDS)+1 bits.

Test Plan:
- Single line, zero-wait core: req with addr 0x0123457 → ack pulses exactly 1 cycle after req is sampled. core_addr sequence is 0x0123440, 0x0123450, 0x0123460, 0x0123470. 16 rdvalid pulses carry the core data in order, and complete follows 1 cycle after the 16th rdvalid.
- Grant stalls: core_gnt held low 5 cycles per command → core_req and core_addr stay stable throughout. Exactly 4 commands are issued, still 16 beats are delivered, and ack is not repeated.
- Interleaved data: core_rvalid for the first command arrives while command 2 is still ungranted → data is forwarded with 1-cycle latency and the count stays correct. Complete occurs only after beat 16 even if the last grant comes later.
- Back-to-back: req held high through complete → a second ack occurs after the return to IDLE with a new base. No beats are lost or merged between lines.
- Unexpected data: core_rvalid pulse in IDLE → no vga_sdram_rdvalid and err_unexpected=1. It stays set through the next normal line.
- Reset mid-burst: assert reset_n=0 after 7 beats → all outputs drop to 0 immediately. No complete is issued. After release, a new req at 0x3FFFFC0 runs a normal line with core_addr wrapping correctly (0x3FFFFC0..0x3FFFFF0).
